// File: rtl/lenet_layer_sched_if.sv
// lenet_layer_sched_if: host start/busy/done handshake, engine layer handshake and layer configuration bundle.
interface lenet_layer_sched_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 start, busy, done, layer_start, layer_done, src_sel, dst_sel, err;
    logic [2:0]           layer_idx, cfg_k;
    logic [1:0]           cfg_type;
    logic [5:0]           cfg_in_w;
    logic [8:0]           cfg_in_ch;
    logic [6:0]           cfg_out_ch;
    logic [CNT_WIDTH-1:0] cycle_count;
    modport master (
        input  start, layer_done,
        output busy, done, layer_start, layer_idx, cfg_type, cfg_k, cfg_in_w, cfg_in_ch,
               cfg_out_ch, src_sel, dst_sel, cycle_count, err
    );
    modport slave (
        output start, layer_done,
        input  busy, done, layer_start, layer_idx, cfg_type, cfg_k, cfg_in_w, cfg_in_ch,
               cfg_out_ch, src_sel, dst_sel, cycle_count, err
    );
endinterface

// File: rtl/lenet_layer_sched.sv
// lenet_layer_sched: walks the 7-layer LeNet-5 table over the shared engine, ping-ponging buffers.
// Define LAYER_WATCHDOG_EN to add a per-layer timeout that aborts the inference and raises err.
module lenet_layer_sched #(
    parameter int N           = 5,
    parameter int MAX_WIDTH   = 32,
    parameter int CNT_WIDTH   = 32,
    parameter int WDOG_CYCLES = 65535
) (
    input logic clk,
    input logic rst,
    lenet_layer_sched_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_NEXT = 3'd3, S_FINISH = 3'd4;
    // Spatial widths follow from valid convolutions and 2x2 pooling.
    localparam int W1 = MAX_WIDTH - N + 1, W2 = W1 / 2, W3 = W2 - N + 1;
    logic [2:0]           state, state_nx, idx;
    logic                 src, accept;
    logic [CNT_WIDTH-1:0] cnt;
    logic [23:0]          row;
    assign accept = state == S_IDLE && bus.start;
`ifdef LAYER_WATCHDOG_EN
    localparam logic [2:0] S_ABORT = 3'd5;
    logic [31:0] wd;
    logic        err;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wd  <= '0;
            err <= 1'b0;
        end else begin
            wd  <= state == S_ISSUE ? '0 : state == S_WAIT ? wd + 32'd1 : wd;
            err <= accept ? 1'b0 : state == S_ABORT ? 1'b1 : err;
        end
    assign bus.err  = err;
    assign bus.done = state == S_FINISH || state == S_ABORT;
`else
    logic unused_wdog;
    assign unused_wdog = ^WDOG_CYCLES;
    assign bus.err     = 1'b0;
    assign bus.done    = state == S_FINISH;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  state_nx = bus.start ? S_ISSUE : S_IDLE;
            S_ISSUE: state_nx = S_WAIT;
`ifdef LAYER_WATCHDOG_EN
            S_WAIT:  state_nx = bus.layer_done ? S_NEXT : wd == 32'(WDOG_CYCLES - 1) ? S_ABORT : S_WAIT;
`else
            S_WAIT:  state_nx = bus.layer_done ? S_NEXT : S_WAIT;
`endif
            S_NEXT:  state_nx = idx == 3'd6 ? S_FINISH : S_ISSUE;
            default: state_nx = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            src   <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx <= '0;
                src <= 1'b0;
                cnt <= '0;
            end else begin
                if (state != S_IDLE && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
                if (state == S_NEXT && idx != 3'd6) begin
                    idx <= idx + 3'd1;
                    src <= ~src;
                end
            end
        end
    // row = {type, in_w, in_ch, out_ch}
    always_comb begin
        row = {2'd2, 6'd1, 9'd84, 7'd10};
        case (idx)
            3'd0:    row = {2'd0, 6'(MAX_WIDTH), 9'd1, 7'd6};
            3'd1:    row = {2'd1, 6'(W1), 9'd6, 7'd6};
            3'd2:    row = {2'd0, 6'(W2), 9'd6, 7'd16};
            3'd3:    row = {2'd1, 6'(W3), 9'd16, 7'd16};
            3'd4:    row = {2'd2, 6'd1, 9'd400, 7'd120};
            3'd5:    row = {2'd2, 6'd1, 9'd120, 7'd84};
            default: ;
        endcase
    end
    assign bus.cfg_type    = row[23:22];
    assign bus.cfg_in_w    = row[21:16];
    assign bus.cfg_in_ch   = row[15:7];
    assign bus.cfg_out_ch  = row[6:0];
    assign bus.cfg_k       = row[23:22] == 2'd0 ? 3'(N) : row[23:22] == 2'd1 ? 3'd2 : 3'd0;
    assign bus.busy        = state != S_IDLE;
    assign bus.layer_start = state == S_ISSUE;
    assign bus.layer_idx   = idx;
    assign bus.src_sel     = src;
    assign bus.dst_sel     = ~src;
    assign bus.cycle_count = cnt;
endmodule

// File: tb/tb_lenet_layer_sched.sv
// tb_lenet_layer_sched: directed and randomized inferences against a cycle-budget model of the layer walk.
// Build with LAYER_WATCHDOG_EN to also exercise the watchdog abort path.
module tb_lenet_layer_sched;
    localparam int WD = 50;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    lenet_layer_sched_if #(.CNT_WIDTH(32)) bus ();
    lenet_layer_sched #(.N(5), .MAX_WIDTH(32), .CNT_WIDTH(32), .WDOG_CYCLES(WD)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int ntests = 0, nfail = 0;
    int dly[7];
    // {type, k, in_w, in_ch, out_ch} straight from the LeNet-5 layer list
    int tbl[7][5] = '{'{0, 5, 32, 1, 6}, '{1, 2, 28, 6, 6}, '{0, 5, 14, 6, 16}, '{1, 2, 10, 16, 16},
                      '{2, 0, 1, 400, 120}, '{2, 0, 1, 120, 84}, '{2, 0, 1, 84, 10}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One inference; the engine answers dly[i] cycles after the first WAIT cycle (dly < 0: silent).
    task automatic run(input bit spur, input int again_at, input int rst_at, input bit abort);
        int k = 0, nls = 0, due = -1, ls_at = 0, done_at = -1, ndone = 0, sum = 0, silent = 7;
        int exp_done;
        logic [26:0] cfg_exp;
        for (int i = 0; i < 7; i++) begin
            if (dly[i] < 0 && silent == 7) silent = i;
            if (dly[i] > 0) sum += dly[i];
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("busy_on", bus.busy, 1);
        check("cnt_clr", bus.cycle_count, 0);
        check("err_clr", bus.err, 0);
        while (k < 3000) begin
            bus.layer_done = 1'b0;
            bus.start = 1'b0;
            if (bus.layer_start) begin
                if (nls > 6) check("extra_layer", nls, 6);
                else begin
                    cfg_exp = {2'(tbl[nls][0]), 3'(tbl[nls][1]), 6'(tbl[nls][2]), 9'(tbl[nls][3]), 7'(tbl[nls][4])};
                    check($sformatf("idx%0d", nls), bus.layer_idx, nls);
                    check($sformatf("cfg%0d", nls),
                          {bus.cfg_type, bus.cfg_k, bus.cfg_in_w, bus.cfg_in_ch, bus.cfg_out_ch}, cfg_exp);
                    check($sformatf("src%0d", nls), bus.src_sel, nls % 2);
                    check($sformatf("dst%0d", nls), bus.dst_sel, (nls % 2) ^ 1);
                    due = dly[nls] < 0 ? -1 : k + 1 + dly[nls];
                end
                ls_at = k;
                if (spur) bus.layer_done = 1'b1;
                nls++;
            end
            if (k == due) bus.layer_done = 1'b1;
            if (again_at >= 0 && nls == again_at + 1 && k == ls_at + 2) bus.start = 1'b1;
            if (rst_at >= 0 && nls == rst_at + 1 && k == ls_at + 3) begin
                bus.layer_done = 1'b0;
                rst = 1'b1;
                #1;
                check("rst_busy", bus.busy, 0);
                check("rst_idx", bus.layer_idx, 0);
                check("rst_done", bus.done, 0);
                check("rst_cnt", bus.cycle_count, 0);
                tick();
                rst = 1'b0;
                return;
            end
            if (bus.done) begin
                ndone++;
                done_at = k;
                break;
            end
            tick();
            k++;
        end
        exp_done = abort ? ls_at + 1 + WD : 21 + sum;
        check("done_seen", ndone, 1);
        check("done_cycle", done_at, exp_done);
        check("layers", nls, abort ? silent + 1 : 7);
        check("err_done", bus.err, abort);
        tick();
        check("busy_off", bus.busy, 0);
        check("done_once", bus.done, 0);
        check("cycles", bus.cycle_count, exp_done + 1);
        check("err_hold", bus.err, abort);
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.layer_done = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        check("r_busy", bus.busy, 0);
        check("r_done", bus.done, 0);
        check("r_ls", bus.layer_start, 0);
        check("r_idx", bus.layer_idx, 0);
        check("r_src", bus.src_sel, 0);
        check("r_dst", bus.dst_sel, 1);
        check("r_err", bus.err, 0);
        check("r_cnt", bus.cycle_count, 0);
        bus.layer_done = 1'b1;
        tick();
        bus.layer_done = 1'b0;
        check("idle_ld_busy", bus.busy, 0);
        check("idle_ld_idx", bus.layer_idx, 0);
        check("idle_ld_ls", bus.layer_start, 0);
        tick();
        for (int i = 0; i < 7; i++) dly[i] = 0;
        run(1'b0, -1, -1, 1'b0);
        for (int i = 0; i < 7; i++) dly[i] = 100;
        run(1'b0, 3, -1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) dly[i] = int'($urandom_range(0, 20));
            run(1'b1, -1, -1, 1'b0);
        end
        for (int i = 0; i < 7; i++) dly[i] = int'($urandom_range(4, 12));
        run(1'b0, -1, 4, 1'b0);
        for (int i = 0; i < 7; i++) dly[i] = int'($urandom_range(0, 5));
        run(1'b1, -1, -1, 1'b0);
`ifdef LAYER_WATCHDOG_EN
        dly = '{3, 3, -1, 0, 0, 0, 0};
        run(1'b0, -1, -1, 1'b1);
        for (int i = 0; i < 7; i++) dly[i] = 1;
        run(1'b0, -1, -1, 1'b0);
`endif
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
